// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Multi-cycle sequencer for the unsigned multiply/divide unit. It owns the
//   architectural HI/LO registers. MULTU uses an iterative shift-add and DIVU
//   uses a restoring divide, one bit per cycle. While a result is pending,
//   any muldiv-class instruction is held off with a stall request. MFHI and
//   MFLO read HI/LO combinationally on mf_out.
//
//   Optional build macro: MULDIV_EARLY_OUT_EN
//     defined   - MULTU finishes once the remaining multiplier bits are zero
//     undefined - MULTU always takes WIDTH cycles
//
//   Ports
//     clk          in   rising-edge clock
//     rst_n        in   asynchronous active-low reset
//     start        in   instruction issue valid
//     alu_ctrl     in   issued ALU control (MULTU/DIVU/MFHI/MFLO acted on)
//     a            in   multiplicand / dividend
//     b            in   multiplier / divisor
//     stall        out  hold request: muldiv-class op issued while busy
//     busy         out  operation in flight
//     hi, lo       out  architectural HI / LO
//     mf_out       out  hi for MFHI, lo for MFLO, else 0
//     div_by_zero  out  one-cycle pulse when a divide by zero completes

typedef enum logic [3:0] {
    ADDac   = 4'd0,
    SUBac   = 4'd1,
    ANDac   = 4'd2,
    ORac    = 4'd3,
    XORac   = 4'd4,
    SLTac   = 4'd5,
    SLLac   = 4'd6,
    SRLac   = 4'd7,
    LUIac   = 4'd8,
    MULTUac = 4'd9,
    DIVUac  = 4'd10,
    MFHIac  = 4'd11,
    MFLOac  = 4'd12
} alu_ctrl_t;

module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32   // 2..64 (6-bit iteration counter)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  alu_ctrl_t        alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_out,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);

    state_t             state;
    state_t             state_nxt;
    logic [5:0]         cnt;
    // MUL: acc is the running product, mcand the left-shifting multiplicand,
    //      mplier the right-shifting multiplier.
    // DIV: acc = {remainder, dividend/quotient}, mplier holds the divisor.
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    logic [2*WIDTH-1:0] acc_mul;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               ge;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   quo_nxt;
    logic               last_iter;
    logic               mul_last;
    logic               dbz;
    logic               accept;

    // One iteration of each algorithm
    always_comb begin
        acc_mul   = acc + (mplier[0] ? mcand : '0);
        shifted   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff      = shifted - {1'b0, mplier};
        ge        = (shifted >= {1'b0, mplier});
        rem_nxt   = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_nxt   = {acc[WIDTH-2:0], ge};
        last_iter = (cnt == CNT_LAST);
        dbz       = (mplier == '0);
`ifdef MULDIV_EARLY_OUT_EN
        // Bits above the one consumed this cycle are all zero: nothing left to add.
        mul_last  = last_iter || (mplier[WIDTH-1:1] == '0);
`else
        mul_last  = last_iter;
`endif
    end

    // Issue decode
    always_comb begin
        accept = start && (state == IDLE) &&
                 ((alu_ctrl == MULTUac) || (alu_ctrl == DIVUac));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (alu_ctrl == DIVUac) ? DIV : MUL;
                end
            end
            MUL: begin
                if (mul_last) begin
                    state_nxt = IDLE;
                end
            end
            DIV: begin
                if (dbz || last_iter) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy   = (state != IDLE);
        stall  = start && busy &&
                 (alu_ctrl inside {MULTUac, DIVUac, MFHIac, MFLOac});
        mf_out = '0;
        if (alu_ctrl == MFHIac) begin
            mf_out = hi;
        end else if (alu_ctrl == MFLOac) begin
            mf_out = lo;
        end
    end

    // Datapath and architectural HI/LO; HI/LO only move on the completion edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            div_by_zero <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        cnt    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, a};
                        mplier <= b;
                        acc    <= (alu_ctrl == DIVUac) ? {{WIDTH{1'b0}}, a} : '0;
                    end
                end
                MUL: begin
                    acc    <= acc_mul;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 6'd1;
                    if (mul_last) begin
                        hi <= acc_mul[2*WIDTH-1:WIDTH];
                        lo <= acc_mul[WIDTH-1:0];
                    end
                end
                DIV: begin
                    if (dbz) begin
                        // Dividend is still untouched in the low half of acc.
                        hi          <= acc[WIDTH-1:0];
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end else begin
                        acc <= {{WIDTH{1'b0}}, quo_nxt} | {rem_nxt, {WIDTH{1'b0}}};
                        cnt <= cnt + 6'd1;
                        if (last_iter) begin
                            hi <= rem_nxt;
                            lo <= quo_nxt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    alu_ctrl_t   alu_ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf_out;
    logic        div_by_zero;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .alu_ctrl    (alu_ctrl),
        .a           (a),
        .b           (b),
        .stall       (stall),
        .busy        (busy),
        .hi          (hi),
        .lo          (lo),
        .mf_out      (mf_out),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    function automatic exp_t model(input alu_ctrl_t op, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        logic [63:0] p;
        e.dbz = 1'b0;
        if (op == MULTUac) begin
            p    = {32'b0, x} * {32'b0, y};
            e.hi = p[63:32];
            e.lo = p[31:0];
`ifdef MULDIV_EARLY_OUT_EN
            e.lat = 1;
            for (int i = 0; i < 32; i++) begin
                if (y[i]) e.lat = i + 1;
            end
`else
            e.lat = 32;
`endif
        end else if (y == 32'd0) begin
            e.hi  = x;
            e.lo  = 32'hFFFF_FFFF;
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
            e.lo  = x / y;
            e.hi  = x % y;
            e.lat = 32;
        end
        return e;
    endfunction

    // Drive a MULTU/DIVU and hold it until accepted; returns 1 time unit
    // after the accept edge with start dropped and operands scrambled.
    task automatic issue(input alu_ctrl_t op, input logic [31:0] x, input logic [31:0] y);
        int waited;
        sb.push_back(model(op, x, y));
        start    = 1'b1;
        alu_ctrl = op;
        a        = x;
        b        = y;
        waited   = 0;
        @(negedge clk);
        while (busy && waited < 200) begin
            check("held_stall", {63'b0, stall}, 64'd1);
            @(negedge clk);
            waited++;
        end
        if (busy) check("accept_timeout", {63'b0, busy}, 64'd0);
        @(posedge clk);
        #1;
        start    = 1'b0;
        alu_ctrl = ADDac;
        a        = $urandom;
        b        = $urandom;
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        @(negedge clk);
        while (busy && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (busy) check("idle_timeout", {63'b0, busy}, 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: tracks HI/LO every cycle, checks results and latency
    initial begin
        int   bcnt;
        logic prev_busy;
        exp_t e;
        bcnt      = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                mhi       = '0;
                mlo       = '0;
                bcnt      = 0;
                prev_busy = 1'b0;
            end else begin
                if (busy) bcnt++;
                if (prev_busy && !busy) begin
                    if (sb.size() == 0) begin
                        check("sb_nonempty", 64'(sb.size()), 64'd1);
                    end else begin
                        e   = sb.pop_front();
                        mhi = e.hi;
                        mlo = e.lo;
                        check("latency", 64'(bcnt), 64'(e.lat));
                        check("dbz_at_done", {63'b0, div_by_zero}, {63'b0, e.dbz});
                    end
                    bcnt = 0;
                end else if (div_by_zero) begin
                    check("dbz_spurious", {63'b0, div_by_zero}, 64'd0);
                end
                prev_busy = busy;
            end
            check("hi_track", {32'b0, hi}, {32'b0, mhi});
            check("lo_track", {32'b0, lo}, {32'b0, mlo});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int ncyc;
        rst_n    = 1'b0;
        start    = 1'b0;
        alu_ctrl = ADDac;
        a        = '0;
        b        = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle MFHI after reset
        start    = 1'b1;
        alu_ctrl = MFHIac;
        @(negedge clk);
        check("rst_mf_out", {32'b0, mf_out}, 64'd0);
        check("rst_stall", {63'b0, stall}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_dbz", {63'b0, div_by_zero}, 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;

        // MULTU max*max, MFHI issued right behind it, then MFLO
        issue(MULTUac, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        start    = 1'b1;
        alu_ctrl = MFHIac;
        ncyc     = 0;
        @(negedge clk);
        while (stall && ncyc < 100) begin
            ncyc++;
            @(negedge clk);
        end
        check("mulff_stall_cycles", 64'(ncyc), 64'd32);
        check("mulff_mfhi", {32'b0, mf_out}, 64'hFFFF_FFFE);
        @(posedge clk);
        #1;
        alu_ctrl = MFLOac;
        @(negedge clk);
        check("mulff_mflo", {32'b0, mf_out}, 64'h0000_0001);
        @(posedge clk);
        #1;
        start = 1'b0;

        // DIVU 100/7 with a MULTU queued behind it (back-to-back accept)
        issue(DIVUac, 32'd100, 32'd7);
        issue(MULTUac, 32'h1234_5678, 32'h0000_9ABC);
        @(negedge clk);
        check("b2b_busy", {63'b0, busy}, 64'd1);
        wait_idle();

        // Divide by zero
        issue(DIVUac, 32'h0000_1234, 32'd0);
        @(negedge clk);
        check("dbz_busy_e0", {63'b0, busy}, 64'd1);
        @(negedge clk);
        check("dbz_pulse", {63'b0, div_by_zero}, 64'd1);
        check("dbz_busy_e1", {63'b0, busy}, 64'd0);
        check("dbz_hi", {32'b0, hi}, 64'h0000_1234);
        check("dbz_lo", {32'b0, lo}, 64'hFFFF_FFFF);
        @(negedge clk);
        check("dbz_pulse_end", {63'b0, div_by_zero}, 64'd0);
        @(posedge clk);
        #1;

        // MULTU 3*5 with a non-muldiv issue during busy
        issue(MULTUac, 32'd3, 32'd5);
        start    = 1'b1;
        alu_ctrl = ADDac;
        @(negedge clk);
        check("nonmd_stall", {63'b0, stall}, 64'd0);
        check("nonmd_busy", {63'b0, busy}, 64'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        check("mul35_hi", {32'b0, hi}, 64'd0);
        check("mul35_lo", {32'b0, lo}, 64'd15);

        // A few random operations
        for (int i = 0; i < 6; i++) begin
            logic [31:0] x;
            logic [31:0] y;
            x = $urandom;
            y = (i < 2) ? $urandom_range(300, 1) : $urandom;
            if (i == 4) y = 32'h0000_0100;
            issue((i % 2) ? DIVUac : MULTUac, x, y);
        end
        wait_idle();

        // Seed HI/LO = 100/7, then reset in the middle of DIVU 9/2
        issue(DIVUac, 32'd1500, 32'd200);
        wait_idle();
        check("seed_hi", {32'b0, hi}, 64'd100);
        check("seed_lo", {32'b0, lo}, 64'd7);
        issue(DIVUac, 32'd9, 32'd2);
        start    = 1'b1;
        alu_ctrl = MFHIac;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {63'b0, busy}, 64'd0);
        check("rst_mid_hi", {32'b0, hi}, 64'd0);
        check("rst_mid_lo", {32'b0, lo}, 64'd0);
        check("rst_mid_stall", {63'b0, stall}, 64'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        alu_ctrl = MFLOac;
        @(negedge clk);
        check("post_rst_mflo", {32'b0, mf_out}, 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the unsigned multiply/divide resource and its HI/LO registers. It decodes `MULTUac`/`DIVUac`/`MFHIac`/`MFLOac` from the issued `alu_ctrl`, runs an iterative shift-add multiply or restoring divide, and owns HI/LO. It raises a stall to the datapath while a result is pending and exposes the HI/LO read value for `MFHI`/`MFLO` through the `SEL_RESULT_ALU_OUT` path.

## Interface
- `WIDTH`, 32, operand and HI/LO width; must be ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  instruction issue valid from decode.
- `alu_ctrl`  in  `alu_ctrl_t`  issued ALU control; only `MULTUac`, `DIVUac`, `MFHIac`, `MFLOac` are acted on.
- `a`  in  WIDTH  rs operand: multiplicand or dividend.
- `b`  in  WIDTH  rt operand: multiplier or divisor.
- `stall`  out  1  combinational hold request to PC/pipeline.
- `busy`  out  1  operation in flight (registered).
- `hi`  out  WIDTH  architectural HI (registered).
- `lo`  out  WIDTH  architectural LO (registered).
- `mf_out`  out  WIDTH  combinational: `hi` for `MFHIac`, `lo` for `MFLOac`, else 0.
- `div_by_zero`  out  1  one-cycle pulse on divide-by-zero completion.

## Operation
- States: IDLE, MUL, DIV. A 6-bit iteration counter is used.
- Op = `start` && `alu_ctrl` ∈ {MULTUac, DIVUac, MFHIac, MFLOac}.
- `stall` = op && `busy`. Non-muldiv instructions never stall.
- Accept occurs on the edge where `start` && MULTU/DIVU && !`busy`. On accept, `a` and `b` are latched into internal registers, the counter is cleared, and the FSM enters MUL or DIV.
- MUL: unsigned shift-add. `b` is consumed LSB-first with one bit per cycle. The accumulator is 2·WIDTH bits.
- DIV: restoring division, one quotient bit per cycle.
- Completion: the final iteration edge writes `hi`/`lo` and returns the FSM to IDLE.
  - MULTU: {hi,lo} = a·b.
  - DIVU: lo = quotient, hi = remainder.
- Divide by zero: no iterations run. At the first edge after accept, lo = all ones, hi = a, `div_by_zero` pulses for one cycle, and the FSM returns to IDLE.
- `hi`/`lo` hold their previous values for the whole time an operation is in flight. Intermediate values are never visible.
- MFHI/MFLO while not busy: `mf_out` is valid in the same cycle, and HI/LO are unchanged.

## Timing
- Reset values: state IDLE, `busy`=0, `stall`=0, `hi`=0, `lo`=0, `div_by_zero`=0, counter 0.
- Accept at edge E0:
  - `busy`=1 from E0 until the completion edge.
  - Completion is at E`WIDTH` (`WIDTH` busy cycles); divide by zero completes at E1.
- Completion-edge cycle: `busy`=1, so `stall` is still asserted for a pending op. In the next cycle `busy`=0, the op is accepted, and `mf_out` shows the new `hi`/`lo`.
- A MULTU/DIVU issued while busy is stalled, not dropped. It is accepted in the first not-busy cycle, back-to-back with the previous completion.
- A non-muldiv `start` while busy is ignored by this block. The in-flight operation continues.
- Reset asserted mid-operation: immediate return to IDLE, HI/LO cleared, and the operation is lost.
- Operand changes after the accept edge have no effect.

## Configuration
- `MULDIV_EARLY_OUT_EN`:
  - Defined: MUL completes at the first iteration edge after which the remaining unconsumed multiplier bits are all zero.
    - b=0 completes at E1.
    - b=5 completes at E3.
    - DIV latency is unchanged.
  - Undefined: MUL always takes exactly `WIDTH` cycles.

## Test plan
- Reset, then idle MFHI: `hi`=`lo`=`mf_out`=0, `stall`=0.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, with MFHI then MFLO issued the next cycle:
  - `stall` is high for 32 cycles.
  - Then `mf_out`=0xFFFFFFFE (HI), followed by 0x00000001 (LO).
  - With `MULDIV_EARLY_OUT_EN` defined, latency is still 32 because b has the top bit set.
- DIVU a=100, b=7: after 32 cycles `lo`=14 and `hi`=2. A following MULTU held during busy is accepted on the cycle `busy` falls.
- DIVU a=0x1234, b=0: at E1 `lo`=0xFFFFFFFF, `hi`=0x1234, and `div_by_zero` pulses for exactly one cycle.
- MULTU a=3, b=5:
  - `{hi,lo}` = 0:15.
  - Completion is at E32 without the macro and at E3 with it.
  - Prior HI/LO values stay visible until the completion edge.
- Seed HI/LO with 100/7, start DIVU 9/2, and assert `rst_n`=0 at E10: `busy`, `hi`, `lo`, and `stall` go to 0 immediately. After release, an idle MFLO gives `mf_out`=0.
